// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read packer.
// The lane helper is used to build partial-word byte enables.
package fifo_pkg;

   localparam int NBYTES_DEFAULT = 4;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DRAIN   = 2'd1,
      EMIT    = 2'd2
   } pack_state_t;

   // True when lane index `lane` lies below a fill count `cnt`.
   function automatic logic lane_filled(input logic [3:0] lane, input logic [3:0] cnt);
      return lane < cnt;
   endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Byte FIFO read side, flush handshake and packed-word stream of the packer.
// The master modport is the packer itself; the slave modport is its environment.
interface fifo_rd_packer_if
   import fifo_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEFAULT
);
   logic                  fifo_empty;
   logic                  fifo_rd_en;
   logic [7:0]            fifo_data;
   logic                  flush;
   logic                  flush_done;
   logic                  word_valid;
   logic                  word_ready;
   logic [8*NBYTES-1:0]   word_data;
   logic [NBYTES-1:0]     word_be;

   modport master (
      input  fifo_empty, fifo_data, flush, word_ready,
      output fifo_rd_en, flush_done, word_valid, word_data, word_be
   );

   modport slave (
      output fifo_empty, fifo_data, flush, word_ready,
      input  fifo_rd_en, flush_done, word_valid, word_data, word_be
   );
endinterface

// File: rtl/pack_out_reg.sv
// Output holding register for packed words with a valid/ready handshake.
// Contents stay frozen while a word is offered but not yet taken.
module pack_out_reg
   import fifo_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEFAULT
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [8*NBYTES-1:0] load_data,
   input  logic [NBYTES-1:0]   load_be,
   input  logic                word_ready,
   output logic                slot_free,
   output logic                word_valid,
   output logic [8*NBYTES-1:0] word_data,
   output logic [NBYTES-1:0]   word_be
);

   logic                valid_reg;
   logic [8*NBYTES-1:0] data_reg;
   logic [NBYTES-1:0]   be_reg;

   // The slot may be refilled on the same edge the current word is taken.
   assign slot_free = !valid_reg || word_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         be_reg    <= '0;
      end else if (load) begin
         valid_reg <= 1'b1;
         data_reg  <= load_data;
         be_reg    <= load_be;
      end else if (word_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign word_valid = valid_reg;
   assign word_data  = data_reg;
   assign word_be    = be_reg;

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a byte FIFO with one-cycle read latency and packs bytes into NBYTES-wide
// words, first byte in lane 0; a flush pushes out any partial word.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst,
   fifo_rd_packer_if.master bus
);

   localparam int         W        = 8 * NBYTES;
   localparam logic [3:0] FULL_CNT = 4'(NBYTES);

   pack_state_t       state_reg;
   pack_state_t       state_next;
   logic [3:0]        byte_cnt_reg;
   logic [3:0]        byte_cnt_next;
   logic [3:0]        cnt_after;
   logic              inflight_reg;
   logic [W-1:0]      asm_reg;
   logic [W-1:0]      asm_next;
   logic [W-1:0]      asm_merged;
   logic [NBYTES-1:0] part_be;
   logic [NBYTES-1:0] load_be;
   logic              rd_en;
   logic              word_full;
   logic              slot_free;
   logic              load;
   logic              emit_partial;
   logic              flush_done;

   // Fill level counting the byte arriving this cycle; a full level with no
   // byte in flight means a completed word is parked waiting for the slot.
   assign cnt_after = byte_cnt_reg + {3'b000, inflight_reg};
   assign word_full = (cnt_after == FULL_CNT);

   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
         assign asm_merged[gi*8 +: 8] = (inflight_reg && byte_cnt_reg == 4'(gi))
                                        ? bus.fifo_data : asm_reg[gi*8 +: 8];
         assign part_be[gi] = lane_filled(4'(gi), byte_cnt_reg);
      end
   endgenerate

   // Counting the in-flight byte stops the read stream exactly at a word boundary.
   assign rd_en = rst && !bus.fifo_empty && (state_reg == COLLECT) && !bus.flush
                  && (cnt_after < FULL_CNT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= COLLECT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         COLLECT: if (bus.flush) state_next = DRAIN;
         DRAIN:   if (!inflight_reg) state_next = EMIT;
         EMIT:    if (byte_cnt_reg == 4'd0 || slot_free) state_next = COLLECT;
         default: state_next = COLLECT;
      endcase
   end

   always_comb begin
      flush_done   = 1'b0;
      emit_partial = 1'b0;
      if (state_reg == EMIT) begin
         if (byte_cnt_reg == 4'd0) begin
            flush_done = 1'b1;
         end else if (slot_free) begin
            flush_done   = 1'b1;
            emit_partial = 1'b1;
         end
      end
   end

   // A full word also covers a flush that finds all lanes already written.
   assign load    = slot_free && (word_full || emit_partial);
   assign load_be = word_full ? {NBYTES{1'b1}} : part_be;

   assign byte_cnt_next = load ? 4'd0 : cnt_after;
   assign asm_next      = load ? '0 : asm_merged;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt_reg <= 4'd0;
         inflight_reg <= 1'b0;
         asm_reg      <= '0;
      end else begin
         byte_cnt_reg <= byte_cnt_next;
         inflight_reg <= rd_en;
         asm_reg      <= asm_next;
      end
   end

   pack_out_reg #(
      .NBYTES (NBYTES)
   ) u_out (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_data  (asm_merged),
      .load_be    (load_be),
      .word_ready (bus.word_ready),
      .slot_free  (slot_free),
      .word_valid (bus.word_valid),
      .word_data  (bus.word_data),
      .word_be    (bus.word_be)
   );

   assign bus.fifo_rd_en = rd_en;
   assign bus.flush_done = flush_done;

endmodule
